// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative radix-2 multiply/divide with architectural HI/LO registers and pipeline stall
module ex_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   input  logic             abort,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             done,
   output logic             div_by_zero
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t state, state_nx;
   logic [1:0] op_r;
   logic sa_r, sb_r, dbz_r;
   logic [WIDTH-1:0] m_r, abs_a, abs_b, quo_fix, rem_fix;
   logic [2*WIDTH-1:0] acc, step, prod;
   logic [CW-1:0] cnt;
   logic [WIDTH:0] sum, trial;
   logic accept, b_zero;
   assign accept = state == IDLE & start & ~abort;
   assign b_zero = op[1] & (operand_b == '0);
   assign abs_a = (~op[0] & operand_a[WIDTH-1]) ? -operand_a : operand_a;
   assign abs_b = (~op[0] & operand_b[WIDTH-1]) ? -operand_b : operand_b;
   // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
   assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m_r} : '0);
   assign trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, m_r};
   assign step = op_r[1] ? (trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                         : {sum, acc[WIDTH-1:1]};
   assign prod = (~op_r[0] & (sa_r ^ sb_r)) ? -acc : acc;
   assign quo_fix = (~op_r[0] & (sa_r ^ sb_r)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_fix = (~op_r[0] & sa_r) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   assign done = state == DONE;
   assign div_by_zero = done & dbz_r;
   always_comb begin
      state_nx = state;
      stall = (state == IDLE & start) | state == CALC | state == FIX;
      if (abort) state_nx = IDLE;
      else
         case (state)
            IDLE:    if (start) state_nx = b_zero ? DONE : CALC;
            CALC:    if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
            FIX:     state_nx = DONE;
            default: state_nx = IDLE;
         endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_r  <= '0;
         sa_r  <= 1'b0;
         sb_r  <= 1'b0;
         dbz_r <= 1'b0;
         m_r   <= '0;
         acc   <= '0;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         if (accept) begin
            op_r  <= op;
            sa_r  <= operand_a[WIDTH-1];
            sb_r  <= operand_b[WIDTH-1];
            dbz_r <= b_zero;
            m_r   <= op[1] ? abs_b : abs_a;
            acc   <= {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
            cnt   <= '0;
         end else if (state == CALC) begin
            acc <= step;
            cnt <= cnt + 1'b1;
         end
         if (state == FIX & ~abort) {hi, lo} <= op_r[1] ? {rem_fix, quo_fix} : prod;
         // start has priority over MTHI/MTLO in IDLE
         if (((state == IDLE & ~start) | state == DONE) & ~abort) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
         end
      end
   end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the operand buses and the decoded mul/div operation latched by ID/EX.
- Owns the architectural HI/LO registers.
- Raises a stall that freezes IF/ID and ID/EX while an operation is in flight.
- Serves MULT/MULTU/DIV/DIVU, MTHI/MTLO writes and MFHI/MFLO reads.

Parameters:
- WIDTH, 32, operand and HI/LO width. The iteration counter is clog2(WIDTH) bits wide.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  EX-stage instruction is a mul/div operation. Level signal, held while stalled.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled when start is accepted.
- operand_a  input  WIDTH  rs value (DataBus_A from ID/EX, after forwarding)
- operand_b  input  WIDTH  rt value (DataBus_B from ID/EX, after forwarding)
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  WIDTH  MTHI/MTLO data
- abort  input  1  kill the in-flight operation (exception flush)
- stall  output  1  freeze IF/ID and ID/EX. Combinational.
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- done  output  1  one-cycle pulse when the result is committed to HI/LO
- div_by_zero  output  1  one-cycle pulse, coincident with done, on DIV/DIVU with operand_b == 0

Behaviour:
- Reset (async, active-low): state=IDLE; hi=0, lo=0, done=0, div_by_zero=0, counter=0, stall=0. Reset mid-operation discards all work.
- States: IDLE, CALC, FIX, DONE.
- stall = (IDLE & start) | CALC | FIX. stall is 0 in DONE.
- IDLE & start & ~abort:
  - Latch op and the sign flags of operand_a and operand_b.
  - For signed ops, latch the absolute values of both operands; for unsigned ops, latch them raw.
  - Clear the counter.
  - If op is DIV/DIVU and operand_b==0, go to DONE with div_by_zero=1; otherwise go to CALC.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - After WIDTH steps (counter == WIDTH-1), go to FIX.
- FIX (1 cycle): apply signs, then write HI/LO.
  - MULT: negate the 2*WIDTH product if the signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Product: HI = upper half, LO = lower half.
  - Division: LO = quotient, HI = remainder.
  - Go to DONE.
- DONE: done=1 for this cycle. stall=0, so the pipeline advances on this edge. start is ignored (it is the same instruction). Next state is IDLE unconditionally.
- Latency: start seen in IDLE at cycle 0.
  - stall is high in cycles 0..WIDTH+1 (34 cycles at WIDTH=32).
  - DONE is cycle WIDTH+2, with hi/lo valid from that cycle.
  - Divide-by-zero: stall is high in cycle 0 only; DONE is cycle 1; HI/LO are unchanged.
- Overflow case -2^31 / -1 (signed): quotient=0x80000000, remainder=0. No flag is raised.
- Back-to-back mul/div: the next op reaches EX after the DONE edge, finds IDLE, and is accepted immediately.
- hi_we/lo_we:
  - Take effect at the edge in IDLE or DONE.
  - Ignored in CALC/FIX; they cannot occur there while the pipeline is stalled.
  - If both start and a write enable are asserted in IDLE, start wins and the write is dropped.
- abort:
  - In any state, forces IDLE at the next edge with HI/LO unchanged.
  - No done or div_by_zero pulse is produced.
  - stall follows the state-based equation, except that IDLE & start & abort does not start an operation.
- MFHI/MFLO read hi/lo directly. An MFHI/MFLO behind a busy unit is held by stall, so no interlock is needed here.

Test Plan:
- MULT, a=7, b=0xFFFFFFFD (-3) -> stall high 34 cycles, done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; start held through DONE does not restart the op.
- DIV, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU, a=100, b=7 -> lo=14, hi=2.
- DIVU, a=100, b=0 with hi=0x11, lo=0x22 -> stall 1 cycle; done and div_by_zero pulse together at cycle 1; hi/lo stay 0x11/0x22. Also signed DIV, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT started, abort at cycle 10 -> IDLE at cycle 11, stall low, no done, hi/lo unchanged. Repeat with reset deasserted→asserted at cycle 20 -> all outputs 0 immediately (async).
- MTLO wdata=0xDEADBEEF in IDLE -> lo=0xDEADBEEF next cycle. Back-to-back MULT then DIV -> second op accepted in the cycle after DONE, total 70 cycles. hi_we together with start -> write dropped.
